// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - start/busy/done handshake and HI/LO result bundle for muldiv_iter
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    // Pipeline side: issues operations and consumes results
    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, div_zero
    );

    // Unit side
    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider with HI/LO result registers
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_iter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    // Shared iteration counter; both engines retire one bit per cycle
    logic [CNT_W-1:0]   r_cnt;
    // MUL: {partial product high, multiplier shifting out}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0] r_acc;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_orig;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b_zero;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;
    logic               w_busy;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_div_next;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    // Operand magnitudes; op[0]=0 selects the signed variants
    always_comb begin
        w_a_neg = ~bus.op[0] & bus.a[WIDTH-1];
        w_b_neg = ~bus.op[0] & bus.b[WIDTH-1];
        w_a_mag = w_a_neg ? -bus.a : bus.a;
        w_b_mag = w_b_neg ? -bus.b : bus.b;
    end

    // One step of each engine; the carry out of the add becomes the new top bit after the shift
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
        w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_opnd});
        w_sub      = w_rem_sh[WIDTH-1:0] - r_opnd;
        w_div_next = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                          : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end

    // Sign fixup and divide-by-zero override applied in FIN
    always_comb begin
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fin_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_fin_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];
        if (r_b_zero) begin
            w_fin_hi = r_a_orig;
            w_fin_lo = '1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: flush aborts from any active state and also beats a same-cycle start
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_next = bus.op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (bus.flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs: busy spans MUL/DIV/FIN so the stall drops as the result lands
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        bus.busy     = w_busy;
        bus.done     = r_done;
        bus.hi       = r_hi;
        bus.lo       = r_lo;
        bus.div_zero = r_div_zero;
    end

    // Datapath: operand capture, iteration, and HI/LO write-back
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_a_orig   <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_cnt    <= CNT_W'(WIDTH);
                        r_is_div <= bus.op[1];
                        r_opnd   <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_a_mag : w_b_mag)};
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= bus.op[1] & (bus.b == '0);
                        r_a_orig <= bus.a;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIN: begin
                    if (!bus.flush) begin
                        r_hi       <= w_fin_hi;
                        r_lo       <= w_fin_lo;
                        r_done     <= 1'b1;
                        r_div_zero <= r_b_zero;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - scoreboard bench for muldiv_iter
module tb_muldiv_iter;
    localparam int W = 32;

    logic clk;
    logic resetn;
    int   n_vec;
    int   n_err;

    // {div_zero, hi, lo}
    logic [2*W:0] sb_q[$];

    muldiv_iter_if #(.WIDTH(W)) bus();

    muldiv_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint    sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b00: begin p = sa * sb; return {1'b0, p[63:0]}; end
            2'b01: begin p = ua * ub; return {1'b0, p[63:0]}; end
            default: begin
                if (b == '0) return {1'b1, a, {W{1'b1}}};
                if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
                else begin q = ua / ub; r = ua % ub; end
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
        endcase
    endfunction

    // Drive one start pulse; push the expectation only for operations that should complete
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [2*W:0] exp);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns on the falling edge inside the done cycle
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < budget);
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resetn && bus.done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                check("result", {bus.div_zero, bus.hi, bus.lo}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int busy_cyc;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;

        n_vec     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("reset_state", {bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo}, '0);

        // MULT -3 * 5 with latency and busy-width measurement
        @(posedge clk);
        #1;
        issue(2'b00, 32'hFFFFFFFD, 32'd5, 1, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1});
        cyc      = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_cyc++;
        end while (!bus.done && cyc < 100);
        check("mul_latency", cyc, 34);
        check("busy_cycles", busy_cyc, 33);
        check("busy_low_at_done", bus.busy, 0);

        // MULTU max * max
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, {1'b0, 32'hFFFFFFFE, 32'h00000001});
        wait_done(60);

        // DIV -7 / 2, then DIVU 100 / 7 issued in the done cycle
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
        wait_done(60);
        issue(2'b11, 32'd100, 32'd7, 1, {1'b0, 32'd2, 32'd14});
        check("busy_after_done_issue", bus.busy, 1);
        wait_done(60);

        // DIVU by zero, div_zero must be a single-cycle pulse
        issue(2'b11, 32'h1234, 32'd0, 1, {1'b1, 32'h00001234, 32'hFFFFFFFF});
        wait_done(60);
        @(negedge clk);
        check("div_zero_pulse", {bus.done, bus.div_zero}, 2'b00);

        // DIV most-negative / -1 wraps
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, {1'b0, 32'h0, 32'h80000000});
        wait_done(60);

        // MULT 2*3, then a flushed DIVU 50/5
        issue(2'b00, 32'd2, 32'd3, 1, {1'b0, 32'd0, 32'd6});
        wait_done(60);
        issue(2'b11, 32'd50, 32'd5, 0, '0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy_low", bus.busy, 0);
        repeat (40) @(negedge clk);
        check("flush_hilo_kept", {bus.hi, bus.lo}, {32'd0, 32'd6});

        // Same DIVU with reset dropped mid-run
        issue(2'b11, 32'd50, 32'd5, 0, '0);
        repeat (9) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("reset_mid_op", {bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo}, '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("reset_no_done", {bus.busy, bus.hi, bus.lo}, '0);

        // MULTU 3*4 with extra starts while busy
        issue(2'b01, 32'd3, 32'd4, 1, {1'b0, 32'd0, 32'd12});
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(60);
        repeat (40) @(negedge clk);
        check("ignored_start_idle", bus.busy, 0);

        // flush together with start in IDLE: nothing starts
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        issue(2'b00, 32'd5, 32'd5, 0, '0);
        bus.flush = 1'b0;
        check("flush_beats_start", bus.busy, 0);
        repeat (40) @(negedge clk);
        check("flush_beats_start_hilo", {bus.hi, bus.lo}, {32'd0, 32'd12});

        // Random vectors against the reference model, back to back
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (i % 4 == 1) rb = -rb;
            issue(rop, ra, rb, 1, model(rop, ra, rb));
            wait_done(60);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Multi-cycle multiply/divide unit for the EX stage, covering the MULT/MULTU/DIV/DIVU operations.
- Shift-add multiplier and restoring divider share one iteration counter. Each retires 1 bit per cycle.
- Writes a 2*WIDTH result into internal HI/LO registers. Raises busy so the hazard unit stalls the pipeline.
- Generalises the fixed 32-bit single-cycle decode-to-result path to a parametrised width with a start/busy/done handshake and flush.

Parameters:
- WIDTH, 32, operand width in bits. Must be ≥ 4. HI and LO are WIDTH bits each.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation. Sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend). Sampled with start.
- b  in  WIDTH  rt operand (multiplier / divisor). Sampled with start.
- flush  in  1  exception/branch flush. Aborts any in-flight operation.
- busy  out  1  high while an operation is in flight. Drives the stall.
- done  out  1  one-cycle pulse; HI/LO updated in the same cycle.
- hi  out  WIDTH  HI register (product high half / remainder).
- lo  out  WIDTH  LO register (product low half / quotient).
- div_zero  out  1  set with done when a DIV/DIVU had b == 0. Otherwise 0.

Behaviour:
- Reset (resetn = 0, asynchronous):
  - state = IDLE; busy, done, div_zero = 0; hi, lo = 0; counter = 0.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 & flush=0: latch |a| and |b| (magnitudes for signed ops; raw for unsigned), plus result-sign flags.
  - Load counter = WIDTH. Go to MUL (op[1]=0) or DIV (op[1]=1).
  - busy goes high the cycle after start.
- MUL:
  - Each cycle: if multiplier LSB = 1, add multiplicand into the upper half of the 2W accumulator; shift the accumulator right by 1; decrement the counter.
  - When the counter reaches 1, go to FIN.
- DIV:
  - Restoring divide. Each cycle: shift the {rem, quo} pair left by 1; trial-subtract the divisor from rem.
  - If the trial result is non-negative: keep it and set quo LSB = 1. Otherwise restore rem.
  - Decrement the counter. When the counter reaches 1, go to FIN.
- FIN (one cycle):
  - Apply sign fixup. Write hi/lo. Pulse done = 1. Set div_zero. busy = 0. Return to IDLE.
- Latency:
  - start sampled at edge 0; done high in the cycle after edge WIDTH+1 (i.e. WIDTH+2 cycles start-to-done).
  - busy is high for WIDTH+1 cycles.
  - A new start is accepted in the cycle done is high.
- Signed rules:
  - MULT: product negated if sign(a) ≠ sign(b). Result is the full 2W two's complement.
  - DIV: quotient negated if sign(a) ≠ sign(b); remainder takes the sign of a.
  - Truncating division toward zero.
- DIV/DIVU with b == 0:
  - Run the full latency (no early exit). lo = all ones, hi = a (original value). div_zero = 1 with done.
- DIV of most-negative / −1: lo = 1 followed by zeros (wraps), hi = 0, div_zero = 0.
- start while busy: ignored. Operands are not re-sampled.
- flush:
  - In MUL/DIV/FIN, abort and return to IDLE on the next edge. busy = 0 from that edge.
  - No done pulse; hi/lo retain their prior values.
  - flush and start together in IDLE: flush wins, no operation starts.
- Reset mid-operation: immediate return to reset values; no done pulse.
- hi/lo change only in FIN or on reset.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (−3), b=5 -> done at start+34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=100, b=7 issued in the done cycle -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, div_zero=1 for one cycle. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Complete MULT 2×3 (lo=6), then start DIVU 50/5 and assert flush at cycle 10 -> busy low next cycle, no done, hi=0, lo=6 unchanged. Repeat the same DIVU with resetn dropped mid-run -> all outputs 0 immediately.
- start pulsed at cycles 5 and 12 during an active MULTU 3×4 -> single done, lo=12; the second start is not executed.
